// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and lane helpers for the data-memory load/store unit
package dmem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } lsu_state_e;

  // Lanes touched by an access of the given size at byte offset off.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MEM_B:   return 4'b0001 << off;
      MEM_H:   return 4'b0011 << off;
      MEM_W:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Right-align the addressed lanes of a word and extend to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic is_unsigned);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      MEM_B:   return is_unsigned ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      MEM_H:   return is_unsigned ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      MEM_W:   return word;
      default: return 32'h0;
    endcase
  endfunction

  // Halves need even offsets, words need offset 0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == MEM_H) && off[0]) || ((size == MEM_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word array with byte-lane writes and registered read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [3:0]       i_be,
  input  logic [IDX_W-1:0] i_addr,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // Lane-masked write and read-before-write of the addressed word; contents are never reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we && i_be[b]) begin
        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - byte-addressed data memory with RISC-V load/store sizing and seeded init
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_LAT    = 1,
  parameter int INIT_WORDS  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [ADDR_W:0]  ADDR_LIMIT = (ADDR_W + 1)'(DEPTH_WORDS) << 2;
  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'((INIT_WORDS == 0) ? 0 : INIT_WORDS - 1);

  lsu_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic             w_run, w_accept, w_err;
  logic [1:0]       w_off;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_wdata_rep;

  logic             w_arr_we;
  logic [3:0]       w_arr_be;
  logic [IDX_W-1:0] w_arr_addr;
  logic [31:0]      w_arr_wdata, w_arr_rdata;

  logic             r_s1_valid, r_s1_err, r_s1_we, r_s1_uns;
  logic [1:0]       r_s1_size, r_s1_off;
  logic             w_s1_valid, w_s1_err;
  logic [31:0]      w_s1_rdata;

  assign w_run     = (r_state == ST_RUN);
  assign req_ready = w_run;
  assign init_done = w_run;
  assign w_accept  = req_valid & w_run;
  assign w_off     = req_addr[1:0];
  assign w_idx     = req_addr[2 +: IDX_W];
  assign w_err     = ({1'b0, req_addr} >= ADDR_LIMIT) || (req_size == 2'b11) ||
                     is_misaligned(req_size, w_off);

  // Replicate store data across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    w_wdata_rep = req_wdata;
    case (req_size)
      MEM_B:   w_wdata_rep = {4{req_wdata[7:0]}};
      MEM_H:   w_wdata_rep = {2{req_wdata[15:0]}};
      default: w_wdata_rep = req_wdata;
    endcase
  end

  // State and seed counter; reset always restarts seeding from word 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and array-port ownership: the seeder in INIT, the request path in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_arr_we    = 1'b0;
    w_arr_be    = 4'b0000;
    w_arr_addr  = w_idx;
    w_arr_wdata = w_wdata_rep;
    case (r_state)
      ST_INIT: begin
        if (INIT_WORDS == 0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_arr_we    = 1'b1;
          w_arr_be    = 4'b1111;
          w_arr_addr  = r_cnt[IDX_W-1:0];
          w_arr_wdata = 32'(r_cnt);
          w_cnt_nxt   = r_cnt + 1'b1;
          if (r_cnt == INIT_LAST) w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_arr_we = req_valid & req_we & ~w_err;
        w_arr_be = byte_en(req_size, w_off);
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk    (clk),
    .i_we   (w_arr_we),
    .i_be   (w_arr_be),
    .i_addr (w_arr_addr),
    .i_wdata(w_arr_wdata),
    .o_rdata(w_arr_rdata)
  );

  // Capture request attributes alongside the array read so extraction lines up with its data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_we    <= 1'b0;
      r_s1_uns   <= 1'b0;
      r_s1_size  <= 2'b00;
      r_s1_off   <= 2'b00;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_err   <= w_err;
      r_s1_we    <= req_we;
      r_s1_uns   <= req_unsigned;
      r_s1_size  <= req_size;
      r_s1_off   <= w_off;
    end
  end

  assign w_s1_valid = r_s1_valid;
  assign w_s1_err   = r_s1_valid & r_s1_err;
  assign w_s1_rdata = (r_s1_valid && !r_s1_err && !r_s1_we) ?
                      load_extract(w_arr_rdata, r_s1_size, r_s1_off, r_s1_uns) : 32'h0;

  generate
    if (READ_LAT <= 1) begin : g_lat1
      assign rsp_valid = w_s1_valid;
      assign rsp_err   = w_s1_err;
      assign rsp_rdata = w_s1_rdata;
    end else begin : g_latn
      logic [READ_LAT-2:0] r_pv, r_pe;
      logic [31:0]         r_pd [READ_LAT-1];

      // Delay line padding the response out to READ_LAT; data and error are zero when idle.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_pv <= '0;
          r_pe <= '0;
          for (int i = 0; i < READ_LAT - 1; i++) r_pd[i] <= 32'h0;
        end else begin
          r_pv[0] <= w_s1_valid;
          r_pe[0] <= w_s1_err;
          r_pd[0] <= w_s1_rdata;
          for (int i = 1; i < READ_LAT - 1; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pe[i] <= r_pe[i-1];
            r_pd[i] <= r_pd[i-1];
          end
        end
      end

      assign rsp_valid = r_pv[READ_LAT-2];
      assign rsp_err   = r_pe[READ_LAT-2];
      assign rsp_rdata = r_pd[READ_LAT-2];
    end
  endgenerate

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - self-checking bench for dmem_lsu against a byte-level memory model
module tb_dmem_lsu;

  localparam int ADDR_W      = 32;
  localparam int DEPTH_WORDS = 1024;
  localparam int READ_LAT    = 3;
  localparam int INIT_WORDS  = 32;
  localparam int MEM_BYTES   = DEPTH_WORDS * 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, init_done;
  logic [31:0] rsp_rdata;

  typedef struct {
    int          cyc;
    bit          err;
    logic [31:0] data;
  } rsp_t;

  rsp_t        exp_q[$];
  rsp_t        got_q[$];
  rsp_t        mon_r;
  logic [7:0]  model_mem [MEM_BYTES];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          hold_bad = 0;
  bit          mon_en = 0;

  dmem_lsu #(
    .ADDR_W     (ADDR_W),
    .DEPTH_WORDS(DEPTH_WORDS),
    .READ_LAT   (READ_LAT),
    .INIT_WORDS (INIT_WORDS)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .init_done   (init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_valid) begin
        mon_r.cyc  = cyc;
        mon_r.err  = rsp_err;
        mon_r.data = rsp_rdata;
        got_q.push_back(mon_r);
      end else if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
        hold_bad++;
      end
    end
  end

  task automatic model_seed();
    logic [31:0] v;
    for (int w = 0; w < INIT_WORDS; w++) begin
      v = w;
      for (int k = 0; k < 4; k++) model_mem[4*w + k] = v[8*k +: 8];
    end
  endtask

  task automatic issue(input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    rsp_t        e;
    bit          err;
    int          nb, n;
    logic [31:0] v;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL issue_ready_timeout got=%0b exp=1", req_ready);
      req_valid = 1'b0;
      return;
    end
    err = (addr >= MEM_BYTES) || (size == 2'd3) || (size == 2'd1 && addr[0]) ||
          (size == 2'd2 && addr[1:0] != 2'b00);
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    e.cyc = cyc + READ_LAT;
    e.err = err;
    e.data = 32'h0;
    if (!err) begin
      if (we) begin
        for (int k = 0; k < nb; k++) model_mem[addr + k] = wdata[8*k +: 8];
      end else begin
        v = 32'h0;
        for (int k = 0; k < nb; k++) v[8*k +: 8] = model_mem[addr + k];
        if (nb < 4 && !uns && v[8*nb-1]) begin
          for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hFF;
        end
        e.data = v;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle_wait();
    @(negedge clk);
    req_valid = 1'b0;
    repeat (READ_LAT + 2) @(negedge clk);
  endtask

  task automatic test_reset();
    rsp_t e, g;
    int   n;
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < MEM_BYTES; i++) model_mem[i] = 'x;
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%0b exp=0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%0b exp=0", rsp_err); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done got=%0b exp=0", init_done); end
    reset_n = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    model_seed();
    checks++; if (n !== INIT_WORDS) begin failures++; $display("FAIL init_len got=%0d exp=%0d", n, INIT_WORDS); end
    checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL init_done got=%0b exp=1", init_done); end
    issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
    for (int i = 0; i < 6; i++) issue(1'b0, 2'd2, 1'b0, 32'($urandom_range(0, INIT_WORDS - 1)) << 2, 32'h0);
    idle_wait();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin failures++; $display("FAIL init_read missing exp_cyc=%0d", e.cyc); end
      else begin
        g = got_q.pop_front();
        if (g.cyc !== e.cyc || g.err !== e.err || g.data !== e.data) begin
          failures++;
          $display("FAIL init_read cyc=%0d exp_cyc=%0d err=%0b exp_err=%0b data=%h exp_data=%h", g.cyc, e.cyc, g.err, e.err, g.data, e.data);
        end
      end
    end
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL init_read_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_byte_half();
    rsp_t e, g;
    issue(1'b1, 2'd2, 1'b0, 32'h40, 32'h1122_3344);
    issue(1'b1, 2'd0, 1'b0, 32'h41, 32'h0000_00AB);
    issue(1'b1, 2'd1, 1'b0, 32'h42, 32'h0000_BEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 32'h41, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 32'h41, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h42, 32'h0);
    issue(1'b0, 2'd1, 1'b1, 32'h42, 32'h0);
    idle_wait();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin failures++; $display("FAIL byte_half missing exp_cyc=%0d", e.cyc); end
      else begin
        g = got_q.pop_front();
        if (g.cyc !== e.cyc || g.err !== e.err || g.data !== e.data) begin
          failures++;
          $display("FAIL byte_half cyc=%0d exp_cyc=%0d err=%0b exp_err=%0b data=%h exp_data=%h", g.cyc, e.cyc, g.err, e.err, g.data, e.data);
        end
      end
    end
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL byte_half_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_errors();
    rsp_t e, g;
    issue(1'b0, 2'd2, 1'b0, 32'h42, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'h45, 32'h0000_5A5A);
    issue(1'b0, 2'd2, 1'b0, 32'h44, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'(MEM_BYTES), 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'(MEM_BYTES) + 32'h14, 32'hFFFF_FFFF);
    issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
    issue(1'b0, 2'd3, 1'b0, 32'h20, 32'h0);
    issue(1'b1, 2'd3, 1'b0, 32'h18, 32'hFFFF_FFFF);
    issue(1'b0, 2'd2, 1'b0, 32'h18, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'(MEM_BYTES - 4), 32'hCAFE_F00D);
    issue(1'b0, 2'd2, 1'b0, 32'(MEM_BYTES - 4), 32'h0);
    issue(1'b0, 2'd0, 1'b0, 32'(MEM_BYTES - 1), 32'h0);
    idle_wait();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin failures++; $display("FAIL errors missing exp_cyc=%0d", e.cyc); end
      else begin
        g = got_q.pop_front();
        if (g.cyc !== e.cyc || g.err !== e.err || g.data !== e.data) begin
          failures++;
          $display("FAIL errors cyc=%0d exp_cyc=%0d err=%0b exp_err=%0b data=%h exp_data=%h", g.cyc, e.cyc, g.err, e.err, g.data, e.data);
        end
      end
    end
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL errors_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_back_to_back();
    rsp_t e, g;
    for (int w = 1; w <= 4; w++) issue(1'b0, 2'd2, 1'b0, 32'(w * 4), 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'h80, 32'hDEAD_BEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
    idle_wait();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin failures++; $display("FAIL back_to_back missing exp_cyc=%0d", e.cyc); end
      else begin
        g = got_q.pop_front();
        if (g.cyc !== e.cyc || g.err !== e.err || g.data !== e.data) begin
          failures++;
          $display("FAIL back_to_back cyc=%0d exp_cyc=%0d err=%0b exp_err=%0b data=%h exp_data=%h", g.cyc, e.cyc, g.err, e.err, g.data, e.data);
        end
      end
    end
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL back_to_back_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_random();
    rsp_t        e, g;
    int          r;
    logic [1:0]  sz;
    logic [31:0] a;
    for (int w = 64; w < 128; w++) issue(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        req_valid = 1'b0;
      end
      r  = $urandom_range(0, 15);
      sz = (r == 15) ? 2'd3 : 2'(r % 3);
      if ($urandom_range(0, 9) == 0) a = 32'h1100 + 32'($urandom_range(0, 255));
      else a = 32'h100 + 32'($urandom_range(0, 255));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end
    idle_wait();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin failures++; $display("FAIL random missing exp_cyc=%0d", e.cyc); end
      else begin
        g = got_q.pop_front();
        if (g.cyc !== e.cyc || g.err !== e.err || g.data !== e.data) begin
          failures++;
          $display("FAIL random cyc=%0d exp_cyc=%0d err=%0b exp_err=%0b data=%h exp_data=%h", g.cyc, e.cyc, g.err, e.err, g.data, e.data);
        end
      end
    end
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL random_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_reset_midflight();
    rsp_t        e, g;
    int          n;
    logic [31:0] v;
    v = $urandom;
    issue(1'b1, 2'd2, 1'b0, 32'h100, v);
    issue(1'b1, 2'd2, 1'b0, 32'h14, 32'hFFFF_0000);
    idle_wait();
    exp_q.delete();
    got_q.delete();
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h44, 32'h0);
    @(negedge clk);
    reset_n = 1'b0;
    req_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    model_seed();
    checks++; if (n !== INIT_WORDS) begin failures++; $display("FAIL midflight_init_len got=%0d exp=%0d", n, INIT_WORDS); end
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL midflight_dropped got=%0d exp=0", got_q.size()); got_q.delete(); end
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
    idle_wait();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin failures++; $display("FAIL midflight missing exp_cyc=%0d", e.cyc); end
      else begin
        g = got_q.pop_front();
        if (g.cyc !== e.cyc || g.err !== e.err || g.data !== e.data) begin
          failures++;
          $display("FAIL midflight cyc=%0d exp_cyc=%0d err=%0b exp_err=%0b data=%h exp_data=%h", g.cyc, e.cyc, g.err, e.err, g.data, e.data);
        end
      end
    end
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL midflight_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_idle_zero();
    checks++;
    if (hold_bad !== 0) begin
      failures++;
      $display("FAIL idle_zero got=%0d exp=0", hold_bad);
    end
  endtask

  initial begin
    test_reset();
    test_byte_half();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    test_idle_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Parametrised successor to the single-port word data memory: byte-addressed data memory with RISC-V load/store sizing (B/H/W, signed/unsigned), byte-lane writes, alignment/range checking, and a configurable-latency response pipeline.
- Runs a sequenced initialisation after reset.
- Sits between the core's MEM stage and the storage array.
- Valid/ready request handshake.
- Fixed-latency response, no response backpressure.

Parameters:
- ADDR_W, 32, request byte-address width.
- DEPTH_WORDS, 1024, number of 32-bit words; power of 2, ≥ 2.
- READ_LAT, 1, cycles from request accept to rsp_valid; legal 1..4.
- INIT_WORDS, 32, words seeded after reset, word i ← i; legal 0..DEPTH_WORDS.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- req_valid  in  1  request present
- req_ready  out  1  block accepts a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends (LBU/LHU); ignored for word and stores
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  one-cycle pulse per accepted request
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, out-of-range, or illegal size
- init_done  out  1  initialisation complete, stays high until next reset

Behaviour:
- Reset is reset_n, synchronous, active-low; clock is clk.
- Reset values:
  - state = INIT, init counter = 0.
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, init_done = 0.
  - All pipeline valids cleared.
  - Array contents are not reset.
- FSM INIT:
  - Each cycle writes mem[cnt] = cnt (zero-extended) and increments cnt.
  - After the write of cnt = INIT_WORDS-1, goes to RUN.
  - INIT_WORDS = 0: goes to RUN on the first cycle after reset.
  - req_ready = 0 throughout INIT; req_valid is ignored.
- FSM RUN:
  - req_ready = 1 and init_done = 1 from the first RUN cycle onwards.
  - Accept = req_valid & req_ready; fully pipelined, one request per cycle.
- Decode at accept:
  - idx = req_addr[2 +: log2(DEPTH_WORDS)], off = req_addr[1:0].
  - Error if any of:
    - req_addr ≥ DEPTH_WORDS*4.
    - size = 11.
    - half with off[0] = 1.
    - word with off ≠ 00.
- Store:
  - Byte enables: B → 1 lane at off; H → 2 lanes at off; W → all 4 lanes.
  - Data is replicated into the lanes.
  - Write commits on the accept edge.
  - Erroring stores write nothing.
- Load:
  - Word read at the accept edge.
  - Data shifted right by 8*off, then sign- or zero-extended per size/req_unsigned.
- Ordering: a load accepted the cycle after a store to the same word returns the stored data.
- Response:
  - Exactly READ_LAT cycles after accept: rsp_valid = 1 for one cycle, with rsp_err and rsp_rdata.
  - Back-to-back accepts give back-to-back responses in order.
  - Between responses, rsp_rdata and rsp_err hold 0.
- Reset mid-operation:
  - In-flight responses are dropped (rsp_valid = 0 the cycle after reset is sampled).
  - Block re-enters INIT and re-seeds words 0..INIT_WORDS-1.
  - Other words retain their contents.
- Reset asserted mid-INIT restarts cnt at 0.

Decomposition:
- Package dmem_pkg:
  - mem_size_e: MEM_B = 2'b00, MEM_H = 2'b01, MEM_W = 2'b10.
  - Function byte_en(size, off) → 4-bit enable.
  - Function load_extract(word, size, off, unsigned) → 32 bits.
  - Function is_misaligned(size, off).
- Sub-module dmem_array:
  - DEPTH_WORDS × 32.
  - Single port: 4-bit byte-enable write, synchronous read.
  - No reset.
  - Port arbitrated between the INIT sequencer and requests by the FSM.

Test Plan:
- Init sequence, INIT_WORDS = 32: reset for 2 cycles → req_ready low for exactly 32 cycles, then high with init_done = 1. LW 0x0000_0014 → rsp_rdata 0x0000_0005 after READ_LAT cycles, rsp_err = 0.
- Byte and half stores:
  - SW 0x40 ← 0x1122_3344, then SB 0x41 ← 0xAB, then SH 0x42 ← 0xBEEF; then LW 0x40 → 0xBEEF_AB44.
  - LB 0x41 → 0xFFFF_FFAB; LBU 0x41 → 0x0000_00AB; LH 0x42 → 0xFFFF_BEEF; LHU 0x42 → 0x0000_BEEF.
- Errors:
  - LW 0x42 → rsp_err = 1, rdata 0.
  - SH 0x45 → rsp_err = 1; memory at 0x44 unchanged.
  - Address 4*DEPTH_WORDS → rsp_err = 1.
  - size 11 → rsp_err = 1.
- Pipelining, READ_LAT = 3: 4 back-to-back loads of words 1..4 → rsp_valid high on 4 consecutive cycles starting 3 cycles after the first accept, data 1, 2, 3, 4 in order.
- Store→load hazard: SW 0x80 ← 0xDEAD_BEEF at cycle t, LW 0x80 at t+1 → 0xDEAD_BEEF.
- Reset mid-flight: issue 2 loads; assert reset the cycle after the second accept → no rsp_valid pulses afterwards; INIT restarts. A word previously stored at 0x100 still reads back its stored value after init_done.
